// File: rtl/pio_edge_capture_in_pkg.sv
// Shared constants for the edge-capture input PIO: register word addresses and edge modes.
package pio_edge_pkg;
    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_MODE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_COUNT = 3'd4;

    // Encoding 2'b11 is not named; it behaves as EDGE_RISE.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_ANY  = 2'b10
    } edge_mode_t;
endpackage

// File: rtl/pio_edge_capture_in_if.sv
// Avalon-MM s1 slave bus of the edge-capture input PIO.
interface pio_edge_capture_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_edge_capture_in_glitch_filter.sv
// One input bit: synchronizer chain followed by a stability filter.
// The filtered output only follows the synchronized input once it has differed for FILTER_CYCLES clocks.
module pio_glitch_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign filt = sync;
        end else begin : g_filt
            localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            logic [CW-1:0] cnt;
            logic          filt_q;

            // cnt counts consecutive cycles in which sync disagrees with the accepted value
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    filt_q <= 1'b0;
                end else if (sync == filt_q) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                    cnt    <= '0;
                    filt_q <= sync;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign filt = filt_q;
        end
    endgenerate
endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO with per-bit edge capture, selectable edge mode and glitch filter.
// Optional bit-0 event counter at address 4 is built when PIO_EDGE_COUNT_EN is defined.
module pio_edge_capture_in
    import pio_edge_pkg::*;
#(
    parameter int         WIDTH         = 1,
    parameter int         SYNC_STAGES   = 2,
    parameter int         FILTER_CYCLES = 0,
    parameter logic [1:0] EDGE_MODE_RST = 2'b00,
    parameter int         CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pio_edge_capture_in_if.slave  s1,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    logic [WIDTH-1:0] filt, prev, rise, fall, qual;
    logic [WIDTH-1:0] irq_mask, edge_cap;
    logic [1:0]       mode;
    logic             wr_en, wr_mode, wr_mask, wr_edge, wr_count;
    logic [31:0]      rd_mux, cnt_rd;
    logic             unused_wd;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_glitch_filter #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_flt (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[i]),
                .filt   (filt[i])
            );
        end
    endgenerate

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

    always_comb begin
        qual = rise;
        case (mode)
            EDGE_FALL: qual = fall;
            EDGE_ANY:  qual = rise | fall;
            default:   qual = rise;
        endcase
    end

    assign wr_en     = s1.chipselect & ~s1.write_n;
    assign wr_mode   = wr_en && (s1.address == ADDR_MODE);
    assign wr_mask   = wr_en && (s1.address == ADDR_MASK);
    assign wr_edge   = wr_en && (s1.address == ADDR_EDGE);
    assign wr_count  = wr_en && (s1.address == ADDR_COUNT);
    assign unused_wd = ^s1.writedata;

    // New edges are OR-ed in after the W1C so a same-cycle clear cannot lose an event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            mode     <= EDGE_MODE_RST;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            prev <= filt;
            if (wr_mode) mode     <= s1.writedata[1:0];
            if (wr_mask) irq_mask <= s1.writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~(wr_edge ? s1.writedata[WIDTH-1:0] : '0)) | qual;
        end
    end

`ifdef PIO_EDGE_COUNT_EN
    logic [CNT_W-1:0] evt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       evt_cnt <= '0;
        else if (wr_count)  evt_cnt <= qual[0] ? CNT_W'(1) : '0;
        else if (qual[0])   evt_cnt <= evt_cnt + CNT_W'(1);
    end

    assign cnt_rd = 32'(evt_cnt);
`else
    logic unused_cnt;
    assign unused_cnt = wr_count;
    assign cnt_rd     = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (s1.address)
            ADDR_DATA:  rd_mux = 32'(filt);
            ADDR_MODE:  rd_mux = {30'd0, mode};
            ADDR_MASK:  rd_mux = 32'(irq_mask);
            ADDR_EDGE:  rd_mux = 32'(edge_cap);
            ADDR_COUNT: rd_mux = cnt_rd;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s1.readdata <= '0;
        else          s1.readdata <= rd_mux;
    end

    assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Self-checking bench: dut0 unfiltered (WIDTH=4, CNT_W=4), dut1 with FILTER_CYCLES=4.
module tb_pio_edge_capture_in;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in0, in1;
    logic       irq0, irq1;
    int         n_cmp = 0;
    int         n_fail = 0;

    pio_edge_capture_in_if bus0 ();
    pio_edge_capture_in_if bus1 ();

    pio_edge_capture_in #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0),
                          .EDGE_MODE_RST(2'b00), .CNT_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .s1(bus0), .in_port(in0), .irq(irq0));

    pio_edge_capture_in #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4),
                          .EDGE_MODE_RST(2'b00), .CNT_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .s1(bus1), .in_port(in1), .irq(irq1));

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0] mode;
        logic [3:0] inv;
        logic [3:0] cap;
        logic       irq;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        if (d == 0) begin
            bus0.address = a; bus0.writedata = v; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = v; bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        end
        @(negedge clk);
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    endtask

    // Expected value is queued when the address is driven and checked when readdata is valid.
    task automatic rd(input int d, input logic [2:0] a, input logic [31:0] e, input string nm);
        sb_t s;
        @(negedge clk);
        if (d == 0) bus0.address = a; else bus1.address = a;
        sb_q.push_back('{nm, e});
        @(negedge clk);
        s = sb_q.pop_front();
        chk(s.nm, (d == 0) ? bus0.readdata : bus1.readdata, s.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'd0, 4'b0110, 4'h6, 1'b1};
        vt[1] = '{2'd0, 4'b0000, 4'h0, 1'b0};
        vt[2] = '{2'd1, 4'b0011, 4'h0, 1'b0};
        vt[3] = '{2'd1, 4'b0001, 4'h2, 1'b1};
        vt[4] = '{2'd2, 4'b1000, 4'h9, 1'b1};
        vt[5] = '{2'd2, 4'b1000, 4'h0, 1'b0};
        vt[6] = '{2'd3, 4'b0001, 4'h1, 1'b1};
        vt[7] = '{2'd1, 4'b0000, 4'h1, 1'b1};
        vt[8] = '{2'd2, 4'b0010, 4'h2, 1'b1};
        vt[9] = '{2'd2, 4'b0000, 4'h2, 1'b1};

        reset_n = 1'b0;
        in0 = '0; in1 = '0;
        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        repeat (3) @(negedge clk);
        chk("reset_irq", 32'(irq0), 32'd0);
        chk("reset_readdata", bus0.readdata, 32'd0);
        reset_n = 1'b1;
        rd(0, 3'd1, 32'd0, "reset_mode");
        rd(0, 3'd2, 32'd0, "reset_mask");
        rd(0, 3'd3, 32'd0, "reset_edge");

        // Rising edge latency: capture and irq appear exactly 3 clocks after in_port changes
        wr(0, 3'd2, 32'hF);
        @(negedge clk); in0 = 4'b0100;
        repeat (2) @(posedge clk);
        #1 chk("lat_irq_early", 32'(irq0), 32'd0);
        @(posedge clk);
        #1 chk("lat_irq_on_time", 32'(irq0), 32'd1);
        rd(0, 3'd3, 32'h4, "lat_edge");
        wr(0, 3'd3, 32'h4);
        rd(0, 3'd3, 32'h0, "w1c_edge");
        chk("w1c_irq", 32'(irq0), 32'd0);
        in0 = 4'b0000;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            wr(0, 3'd1, 32'(vt[i].mode));
            wr(0, 3'd3, 32'hF);
            @(negedge clk); in0 = vt[i].inv;
            repeat (5) @(negedge clk);
            rd(0, 3'd3, 32'(vt[i].cap), $sformatf("vec%0d_edge", i));
            chk($sformatf("vec%0d_irq", i), 32'(irq0), 32'(vt[i].irq));
        end
        rd(0, 3'd1, 32'd2, "mode_readback");
        wr(0, 3'd1, 32'hFFFF_FFFE);
        rd(0, 3'd1, 32'd2, "mode_upper_bits");

        // Edge on bit 0 lands on the same clock as its W1C: edge must survive
        wr(0, 3'd1, 32'd0);
        wr(0, 3'd3, 32'hF);
        @(negedge clk); in0 = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus0.address = 3'd3; bus0.writedata = 32'h1; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        @(negedge clk);
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        rd(0, 3'd3, 32'h1, "collide_edge");
        wr(0, 3'd3, 32'h0);
        rd(0, 3'd3, 32'h1, "w1c_zero");
        wr(0, 3'd3, 32'h1);
        rd(0, 3'd3, 32'h0, "w1c_one");

        // Capture is unconditional; only irq is masked
        wr(0, 3'd2, 32'h1);
        wr(0, 3'd3, 32'hF);
        @(negedge clk); in0 = 4'b1001;
        repeat (5) @(negedge clk);
        rd(0, 3'd3, 32'h8, "mask_edge");
        chk("mask_irq_off", 32'(irq0), 32'd0);
        wr(0, 3'd2, 32'h8);
        chk("mask_irq_on", 32'(irq0), 32'd1);
        wr(0, 3'd5, 32'hFFFF_FFFF);
        rd(0, 3'd5, 32'd0, "addr5");
        rd(0, 3'd0, 32'h9, "data");

        // Event counter: 17 edges wrap a 4-bit counter to 1
        wr(0, 3'd2, 32'h0);
        wr(0, 3'd1, 32'h0);
        @(negedge clk); in0 = 4'b1000;
        repeat (5) @(negedge clk);
        wr(0, 3'd4, 32'h0);
        for (int k = 0; k < 17; k++) begin
            in0[0] = 1'b1;
            repeat (4) @(negedge clk);
            in0[0] = 1'b0;
            repeat (4) @(negedge clk);
        end
`ifdef PIO_EDGE_COUNT_EN
        rd(0, 3'd4, 32'd1, "count_wrap");
`else
        rd(0, 3'd4, 32'd0, "count_absent");
`endif
        wr(0, 3'd4, 32'h5);
        rd(0, 3'd4, 32'd0, "count_clear");

        // Asynchronous reset mid-operation
        in0 = 4'b0001;
        repeat (5) @(negedge clk);
        wr(0, 3'd2, 32'hF);
        rd(0, 3'd0, 32'h1, "pre_reset_data");
        chk("pre_reset_irq", 32'(irq0), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", 32'(irq0), 32'd0);
        chk("async_reset_readdata", bus0.readdata, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(0, 3'd3, 32'h1, "post_reset_edge");
        rd(0, 3'd2, 32'h0, "post_reset_mask");
        chk("post_reset_irq", 32'(irq0), 32'd0);
        rd(0, 3'd1, 32'h0, "post_reset_mode");

        // Filtered instance: latency 2+4+1 and pulse-width rejection
        wr(1, 3'd2, 32'hF);
        @(negedge clk); in1 = 4'b0001;
        repeat (6) @(posedge clk);
        #1 chk("flt_lat_early", 32'(irq1), 32'd0);
        @(posedge clk);
        #1 chk("flt_lat_on_time", 32'(irq1), 32'd1);
        wr(1, 3'd3, 32'hF);
        in1 = 4'b0000;
        repeat (10) @(negedge clk);
        rd(1, 3'd3, 32'h0, "flt_fall_ignored");
        @(negedge clk); in1 = 4'b0010;
        repeat (3) @(negedge clk);
        in1 = 4'b0000;
        repeat (10) @(negedge clk);
        rd(1, 3'd3, 32'h0, "flt_pulse3_edge");
        rd(1, 3'd0, 32'h0, "flt_pulse3_data");
        @(negedge clk); in1 = 4'b0010;
        repeat (4) @(negedge clk);
        in1 = 4'b0000;
        repeat (10) @(negedge clk);
        rd(1, 3'd3, 32'h2, "flt_pulse4_edge");
        rd(1, 3'd0, 32'h0, "flt_pulse4_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
